// File: rtl/scrambler_pkg.sv
// Shared PCS constants for the 64b/66b TX scrambler: block geometry,
// LFSR taps, the scrambled-idle test block and the mode encodings.
package scrambler_pkg;

    localparam int LEN_SCRAMBLER   = 58;
    localparam int LEN_CODED_BLOCK = 66;
    localparam int NB_SH           = 2;
    localparam int NB_PAYLOAD      = LEN_CODED_BLOCK - NB_SH;

    // Taps of x^58 + x^39 + 1 expressed on a state that shifts toward bit 0:
    // bit 19 holds the output from 39 bits ago, bit 0 the one from 58 bits ago.
    localparam int TAP_A = 19;
    localparam int TAP_B = 0;

    // Scrambled-idle test pattern: header 2'b10 followed by an idle payload.
    localparam logic [LEN_CODED_BLOCK-1:0] IDLE_BLOCK = 66'h21E00000000000000;

    // Mode encodings as seen on i_mode / o_mode; 2'b11 is reserved.
    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_BYPASS    = 2'b01,
        MODE_TEST_IDLE = 2'b10
    } mode_e;

    // Map a raw mode request onto a legal state; the reserved code runs.
    function automatic mode_e decode_mode(input logic [1:0] req);
        case (req)
            2'b01:   return MODE_BYPASS;
            2'b10:   return MODE_TEST_IDLE;
            default: return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/scrambler_lfsr_step.sv
// Combinational chained step of the self-synchronous scrambler: applies the
// polynomial to a whole payload, MSB first, and returns the final state.
module scrambler_lfsr_step
    import scrambler_pkg::*;
#(
    parameter int LEN_STATE = LEN_SCRAMBLER,
    parameter int LEN_DATA  = NB_PAYLOAD
)(
    input  logic [LEN_STATE-1:0] i_state,
    input  logic [LEN_DATA-1:0]  i_payload,
    output logic [LEN_DATA-1:0]  o_payload,
    output logic [LEN_STATE-1:0] o_next_state
);

    logic [LEN_STATE-1:0] chain;
    logic                 fb;

    // Unrolled bit-serial scrambler; each scrambled bit is fed back into the state.
    always_comb begin
        chain     = i_state;
        fb        = 1'b0;
        o_payload = '0;
        for (int i = LEN_DATA - 1; i >= 0; i--) begin
            fb           = i_payload[i] ^ chain[TAP_A] ^ chain[TAP_B];
            o_payload[i] = fb;
            chain        = {fb, chain[LEN_STATE-1:1]};
        end
        o_next_state = chain;
    end

endmodule

// File: rtl/scrambler.sv
// TX 64b/66b payload scrambler with bypass and scrambled-idle test mode.
// The sync header passes through untouched; output is registered (1 cycle).
module scrambler #(
    parameter int                           LEN_SCRAMBLER   = scrambler_pkg::LEN_SCRAMBLER,
    parameter int                           LEN_CODED_BLOCK = scrambler_pkg::LEN_CODED_BLOCK,
    parameter logic [LEN_SCRAMBLER-1:0]     SEED            = '0
)(
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [1:0]                 i_mode,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    input  logic                       i_tag,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_tag,
    output logic [1:0]                 o_mode
);

    import scrambler_pkg::*;

    localparam int LEN_PAYLOAD = LEN_CODED_BLOCK - NB_SH;

    mode_e                      mode_q;
    mode_e                      mode_d;
    logic [LEN_SCRAMBLER-1:0]   lfsr_q;
    logic [LEN_SCRAMBLER-1:0]   lfsr_d;
    logic [LEN_SCRAMBLER-1:0]   lfsr_next;
    logic [LEN_CODED_BLOCK-1:0] data_q;
    logic [LEN_CODED_BLOCK-1:0] data_d;
    logic                       valid_q;
    logic                       tag_q;
    logic                       tag_d;
    logic [LEN_PAYLOAD-1:0]     step_in;
    logic [LEN_PAYLOAD-1:0]     step_out;
    logic [LEN_CODED_BLOCK-1:0] idle_block;
    logic                       update;

    assign update     = i_enable & i_valid;
    assign mode_d     = decode_mode(i_mode);
    assign idle_block = IDLE_BLOCK;

    // The request applies to the block it arrives with, so the scrambler input
    // is selected from the requested mode rather than the registered one.
    assign step_in = (mode_d == MODE_TEST_IDLE) ? idle_block[LEN_PAYLOAD-1:0]
                                                : i_data[LEN_PAYLOAD-1:0];

    scrambler_lfsr_step #(
        .LEN_STATE (LEN_SCRAMBLER),
        .LEN_DATA  (LEN_PAYLOAD)
    ) u_step (
        .i_state      (lfsr_q),
        .i_payload    (step_in),
        .o_payload    (step_out),
        .o_next_state (lfsr_next)
    );

    // Mode mux: choose output block, tag and next LFSR state for this block.
    always_comb begin
        data_d = {i_data[LEN_CODED_BLOCK-1 -: NB_SH], step_out};
        lfsr_d = lfsr_next;
        tag_d  = i_tag;
        case (mode_d)
            MODE_BYPASS: begin
                data_d = i_data;
                lfsr_d = lfsr_q;
            end
            MODE_TEST_IDLE: begin
                data_d = {idle_block[LEN_CODED_BLOCK-1 -: NB_SH], step_out};
                tag_d  = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Mode FSM: the state follows the request, but only on a block update.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q <= MODE_RUN;
        end else if (update) begin
            mode_q <= mode_d;
        end
    end

    // Pipeline stage: a valid block loads everything, a bubble only drops valid.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q  <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= 1'b0;
        end else if (i_enable) begin
            valid_q <= i_valid;
            if (i_valid) begin
                lfsr_q <= lfsr_d;
                data_q <= data_d;
                tag_q  <= tag_d;
            end
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_tag   = tag_q;
    assign o_mode  = mode_q;

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for the TX scrambler. Two instances (seed 0 and seed 1)
// share one stimulus stream; a bit-level recurrence model predicts each block
// and an independent descrambler model checks the RX round trip.
module tb_scrambler;

    localparam logic [57:0] SEED0 = 58'h0;
    localparam logic [57:0] SEED1 = 58'h1;
    localparam logic [65:0] IDLE  = 66'h21E00000000000000;
    localparam logic [1:0]  M_RUN = 2'b00;
    localparam logic [1:0]  M_BYP = 2'b01;
    localparam logic [1:0]  M_IDL = 2'b10;
    localparam logic [1:0]  M_RES = 2'b11;

    logic        clock = 1'b0;
    logic        resetN;
    logic        enable;
    logic        valid;
    logic [1:0]  mode;
    logic [65:0] data;
    logic        tag;

    logic [65:0] oData0, oData1;
    logic        oValid0, oValid1, oTag0, oTag1;
    logic [1:0]  oMode0, oMode1;

    int errors = 0;
    int checks = 0;
    int rxCount = 0;

    // Expected outputs per instance.
    logic [65:0] expData[2];
    logic        expValid[2];
    logic        expTag[2];
    logic [1:0]  expMode[2];

    // Bit histories: 0/1 scrambler models, 2 uninterrupted-run reference,
    // 3/4 descramblers (both seeded with SEED1).
    bit hist[5][$];

    always #5 clock = ~clock;

    scrambler #(.SEED(SEED0)) dut0 (
        .i_clock(clock), .i_reset_n(resetN), .i_enable(enable), .i_valid(valid),
        .i_mode(mode), .i_data(data), .i_tag(tag),
        .o_data(oData0), .o_valid(oValid0), .o_tag(oTag0), .o_mode(oMode0)
    );

    scrambler #(.SEED(SEED1)) dut1 (
        .i_clock(clock), .i_reset_n(resetN), .i_enable(enable), .i_valid(valid),
        .i_mode(mode), .i_data(data), .i_tag(tag),
        .o_data(oData1), .o_valid(oValid1), .o_tag(oTag1), .o_mode(oMode1)
    );

    task automatic check(input string name, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // History holds the last 58 transmitted bits, oldest first; the seed
    // stands in for the bits sent before reset.
    task automatic seedHist(input int id, input logic [57:0] sd);
        hist[id].delete();
        for (int j = 0; j < 58; j++) hist[id].push_back(sd[j]);
    endtask

    // Each scrambled bit = data ^ scrambled bit 39 earlier ^ scrambled bit 58 earlier.
    task automatic scrambleModel(input int id, input logic [63:0] pay, output logic [63:0] res);
        bit b;
        res = '0;
        for (int i = 63; i >= 0; i--) begin
            b = pay[i] ^ hist[id][hist[id].size() - 39] ^ hist[id][0];
            res[i] = b;
            hist[id].push_back(b);
            void'(hist[id].pop_front());
        end
    endtask

    // Receiver: data = received ^ received 39 earlier ^ received 58 earlier.
    task automatic descrambleModel(input int id, input logic [63:0] rx, output logic [63:0] res);
        res = '0;
        for (int i = 63; i >= 0; i--) begin
            res[i] = rx[i] ^ hist[id][hist[id].size() - 39] ^ hist[id][0];
            hist[id].push_back(rx[i]);
            void'(hist[id].pop_front());
        end
    endtask

    task automatic modelBlock(input int id, input logic [1:0] m, input logic [65:0] d, input logic t);
        logic [63:0] p;
        expValid[id] = 1'b1;
        case (m)
            M_BYP: begin
                expData[id] = d;
                expTag[id]  = t;
                expMode[id] = M_BYP;
            end
            M_IDL: begin
                scrambleModel(id, IDLE[63:0], p);
                expData[id] = {IDLE[65:64], p};
                expTag[id]  = 1'b0;
                expMode[id] = M_IDL;
            end
            default: begin
                scrambleModel(id, d[63:0], p);
                expData[id] = {d[65:64], p};
                expTag[id]  = t;
                expMode[id] = M_RUN;
            end
        endcase
    endtask

    task automatic checkOutput(input string name);
        logic [65:0] aData[2];
        logic        aValid[2];
        logic        aTag[2];
        logic [1:0]  aMode[2];
        aData[0] = oData0;  aData[1] = oData1;
        aValid[0] = oValid0; aValid[1] = oValid1;
        aTag[0] = oTag0;    aTag[1] = oTag1;
        aMode[0] = oMode0;  aMode[1] = oMode1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_data%0d", name, k), aData[k], expData[k]);
            check($sformatf("%s_valid%0d", name, k), 66'(aValid[k]), 66'(expValid[k]));
            check($sformatf("%s_tag%0d", name, k), 66'(aTag[k]), 66'(expTag[k]));
            check($sformatf("%s_mode%0d", name, k), 66'(aMode[k]), 66'(expMode[k]));
        end
    endtask

    task automatic applyStimulus(input string name, input logic en, input logic v,
                                 input logic [1:0] m, input logic [65:0] d, input logic t);
        enable = en; valid = v; mode = m; data = d; tag = t;
        @(posedge clock);
        #1;
        if (en && v) begin
            modelBlock(0, m, d, t);
            modelBlock(1, m, d, t);
        end else if (en) begin
            expValid[0] = 1'b0;
            expValid[1] = 1'b0;
        end
        checkOutput(name);
    endtask

    // RX round trip: matched seed must recover every block, mismatched seed
    // must recover everything from the second block on.
    task automatic rxCheck(input logic [65:0] sent);
        logic [63:0] rec;
        descrambleModel(3, oData1[63:0], rec);
        check("rx_matched_seed", 66'(rec), 66'(sent[63:0]));
        descrambleModel(4, oData0[63:0], rec);
        if (rxCount > 0) check("rx_seed_mismatch", 66'(rec), 66'(sent[63:0]));
        rxCount++;
    endtask

    task automatic resetExpect();
        for (int k = 0; k < 2; k++) begin
            expData[k] = '0; expValid[k] = 1'b0; expTag[k] = 1'b0; expMode[k] = M_RUN;
        end
        seedHist(0, SEED0);
        seedHist(1, SEED1);
    endtask

    function automatic logic [65:0] rnd66();
        return {2'($urandom_range(0, 3)), $urandom, $urandom};
    endfunction

    initial begin
        logic [65:0] d;
        logic [63:0] refPay;
        resetN = 1'b0; enable = 1'b0; valid = 1'b0; mode = M_RUN; data = '0; tag = 1'b0;
        resetExpect();
        seedHist(3, SEED1);
        seedHist(4, SEED1);
        #2;
        checkOutput("reset_state");
        @(posedge clock);
        #1;
        resetN = 1'b1;

        // All-zero payloads in RUN mode.
        for (int n = 0; n < 10; n++) begin
            d = {2'b01, 64'h0};
            applyStimulus("run_zero", 1'b1, 1'b1, M_RUN, d, 1'b0);
            check("seed0_zero_block", oData0, {2'b01, 64'h0});
            if (n == 0) begin
                check("seed1_hdr", 66'(oData1[65:64]), 66'(2'b01));
                check("seed1_bit63", 66'(oData1[63]), 66'(1'b1));
            end
            rxCheck(d);
        end

        // Random RUN traffic with occasional bubbles.
        for (int n = 0; n < 1000; n++) begin
            d = rnd66();
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus("run_bubble", 1'b1, 1'b0, M_RUN, d, 1'($urandom_range(0, 1)));
            end else begin
                applyStimulus("run_random", 1'b1, 1'b1, M_RUN, d, 1'($urandom_range(0, 1)));
                rxCheck(d);
            end
        end

        // RUN 5, BYPASS 3, RUN 5 against an uninterrupted RUN reference.
        hist[2] = hist[1];
        for (int n = 0; n < 5; n++) begin
            d = rnd66();
            applyStimulus("seq_run_a", 1'b1, 1'b1, M_RUN, d, 1'b1);
            scrambleModel(2, d[63:0], refPay);
            check("seq_ref_a", oData1, {d[65:64], refPay});
        end
        applyStimulus("mode_req_gap", 1'b1, 1'b0, M_BYP, rnd66(), 1'b0);
        for (int n = 0; n < 3; n++) begin
            d = rnd66();
            applyStimulus("seq_bypass", 1'b1, 1'b1, M_BYP, d, 1'b0);
            check("bypass_passthru", oData1, d);
        end
        for (int n = 0; n < 5; n++) begin
            d = rnd66();
            applyStimulus("seq_run_b", 1'b1, 1'b1, M_RUN, d, 1'b0);
            scrambleModel(2, d[63:0], refPay);
            check("seq_ref_b", oData1, {d[65:64], refPay});
        end

        // Scrambled-idle test pattern ignores data and forces tag low.
        for (int n = 0; n < 6; n++) begin
            applyStimulus("test_idle", 1'b1, 1'b1, M_IDL, rnd66(), 1'b1);
            check("idle_hdr", 66'(oData1[65:64]), 66'(2'b10));
        end

        // Reserved mode behaves as RUN.
        for (int n = 0; n < 3; n++) begin
            applyStimulus("reserved", 1'b1, 1'b1, M_RES, rnd66(), 1'b1);
        end

        // Clock enable low freezes everything, including the LFSR.
        for (int n = 0; n < 4; n++) begin
            applyStimulus("freeze", 1'b0, 1'b1, M_RUN, rnd66(), 1'($urandom_range(0, 1)));
        end
        applyStimulus("after_freeze", 1'b1, 1'b1, M_RUN, rnd66(), 1'b1);

        // Asynchronous reset pulse between edges while streaming.
        applyStimulus("pre_reset", 1'b1, 1'b1, M_BYP, rnd66(), 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        resetExpect();
        checkOutput("async_reset");
        #3;
        resetN = 1'b1;
        for (int n = 0; n < 3; n++) begin
            applyStimulus("post_reset", 1'b1, 1'b1, M_RUN, rnd66(), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
